// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide execute unit: shift-add multiplier and restoring
// divider sharing one set of accumulators, with a one-cycle path for RISC-V corner cases.
module ex_muldiv #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;

  // Handshake: a request transfers on a cycle where in_valid && in_ready, a result
  // transfers on a cycle where out_valid && out_ready; flush overrides both.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]      op_q;
  logic            word_q, neg1_q, neg2_q;
  logic [PW-1:0]   acc, sh;
  logic [XLEN-1:0] mq;
  logic [CW-1:0]   cnt;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Request decode, evaluated on the accept cycle
  logic            s1_signed, s2_signed, a_neg, b_neg, is_div;
  logic            div_zero, ovf, illegal, fast;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dividend_w, fast_res;
  logic [CW-1:0]   cnt_init;

  always_comb begin
    s1_signed  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    s2_signed  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    is_div     = op[2];
    a_neg      = s1_signed & (word ? src1[31] : src1[XLEN-1]);
    b_neg      = s2_signed & (word ? src2[31] : src2[XLEN-1]);
    a_ext      = word ? (s1_signed ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]}) : src1;
    b_ext      = word ? (s2_signed ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]}) : src2;
    a_mag      = a_neg ? -a_ext : a_ext;
    b_mag      = b_neg ? -b_ext : b_ext;
    div_zero   = word ? (src2[31:0] == 32'd0) : (src2 == '0);
    ovf        = is_div & ~op[0] &
                 (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                       : (src1 == {1'b1, {(XLEN-1){1'b0}}} && (&src2)));
    illegal    = word & ~op[2] & (op[1:0] != 2'b00);
    fast       = illegal | (is_div & (div_zero | ovf));
    dividend_w = word ? sext32(src1[31:0]) : src1;
    fast_res   = '0;
    if (illegal)       fast_res = '0;
    else if (div_zero) fast_res = op[1] ? dividend_w : '1;
    else if (ovf)      fast_res = op[1] ? '0 : dividend_w;
    if (is_div) cnt_init = CW'(word ? 32 : XLEN);
    else        cnt_init = CW'(word ? 32 / MUL_BITS : XLEN / MUL_BITS);
  end

  // One iteration step: acc/sh/mq are product/multiplicand/multiplier or
  // remainder/divisor/dividend-quotient depending on the latched op.
  logic [MUL_BITS-1:0] digit;
  logic [PW-1:0]       acc_nxt, sh_nxt, prod_s;
  logic [XLEN-1:0]     mq_nxt, diff, rem_s, quo_s, fin_raw, fin_res;
  logic [XLEN:0]       r_sh;
  logic                ge;

  always_comb begin
    digit   = mq[MUL_BITS-1:0];
    r_sh    = {acc[XLEN-1:0], mq[XLEN-1]};
    ge      = r_sh >= {1'b0, sh[XLEN-1:0]};
    diff    = r_sh[XLEN-1:0] - sh[XLEN-1:0];
    acc_nxt = acc;
    sh_nxt  = sh;
    mq_nxt  = mq;
    if (op_q[2]) begin
      acc_nxt = {{XLEN{1'b0}}, (ge ? diff : r_sh[XLEN-1:0])};
      mq_nxt  = {mq[XLEN-2:0], ge};
    end else begin
      acc_nxt = acc + sh * PW'(digit);
      sh_nxt  = sh << MUL_BITS;
      mq_nxt  = mq >> MUL_BITS;
    end
    prod_s = (neg1_q ^ neg2_q) ? -acc_nxt : acc_nxt;
    quo_s  = (neg1_q ^ neg2_q) ? -mq_nxt : mq_nxt;
    rem_s  = neg1_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    if (op_q[2])               fin_raw = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) fin_raw = prod_s[XLEN-1:0];
    else                       fin_raw = prod_s[PW-1:XLEN];
    fin_res = word_q ? sext32(fin_raw[31:0]) : fin_raw;
  end

  logic accept;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          accept    = 1'b1;
          state_nxt = fast ? DONE : CALC;
        end
        CALC: if (cnt == CW'(1)) state_nxt = DONE;
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      word_q <= 1'b0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      acc    <= '0;
      sh     <= '0;
      mq     <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op;
        word_q <= word;
        neg1_q <= a_neg;
        neg2_q <= b_neg;
        acc    <= '0;
        sh     <= {{XLEN{1'b0}}, (is_div ? b_mag : a_mag)};
        // Word dividends are left-justified so the quotient lands in the low 32 bits
        mq     <= is_div ? (word ? (a_mag << (XLEN - 32)) : a_mag) : b_mag;
        cnt    <= cnt_init;
        if (fast) result <= fast_res;
      end else if (state == CALC && !flush) begin
        acc <= acc_nxt;
        sh  <= sh_nxt;
        mq  <= mq_nxt;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) result <= fin_res;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: MUL_BITS=1 and MUL_BITS=4 instances run in lockstep against
// a directed vector table, random vectors checked by a behavioural model, and flush/reset cases.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  op = '0;
  logic        word = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        out_ready = 1'b1;
  logic        in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
  logic [63:0] result1, result4;

  ex_muldiv #(.XLEN(64), .MUL_BITS(1)) u_mb1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .word(word), .src1(src1), .src2(src2), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .busy(busy1));

  ex_muldiv #(.XLEN(64), .MUL_BITS(4)) u_mb4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .word(word), .src1(src1), .src2(src2), .out_valid(out_valid4),
    .out_ready(out_ready), .result(result4), .busy(busy4));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] exp_q1[$], exp_q4[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic w, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] e, input int hold);
    vec_t v;
    v.op = o; v.word = w; v.a = a; v.b = b; v.exp = e; v.hold = hold;
    return v;
  endfunction

  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       ax, bx, p;
    logic signed [31:0] sa, sb, sr;
    logic signed [63:0] la, lb, lr;
    logic [31:0]        r32;
    logic [63:0]        r;
    r32 = '0; r = '0; sa = a[31:0]; sb = b[31:0]; la = a; lb = b; sr = '0; lr = '0;
    if (w) begin
      case (o)
        3'b000: r32 = a[31:0] * b[31:0];
        3'b100: begin
          if (b[31:0] == 0) r32 = '1;
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
          else begin sr = sa / sb; r32 = sr; end
        end
        3'b101: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'b110: begin
          if (b[31:0] == 0) r32 = a[31:0];
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = '0;
          else begin sr = sa % sb; r32 = sr; end
        end
        3'b111: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      ax = (o == 3'b001 || o == 3'b010) ? {{64{a[63]}}, a} : {64'b0, a};
      bx = (o == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ax * bx;
      case (o)
        3'b000: r = p[63:0];
        3'b001, 3'b010, 3'b011: r = p[127:64];
        3'b100: begin
          if (b == 0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else begin lr = la / lb; r = lr; end
        end
        3'b101: if (b == 0) r = '1; else r = a / b;
        3'b110: begin
          if (b == 0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else begin lr = la % lb; r = lr; end
        end
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input int mb);
    int   wd;
    logic dz, ov;
    wd = w ? 32 : 64;
    if (!o[2]) return (w && o != 3'b000) ? 1 : wd / mb + 1;
    dz = w ? (b[31:0] == 0) : (b == 0);
    ov = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (dz || ov) ? 1 : wd + 1;
  endfunction

  // Called and returns on a negative clock edge.
  task automatic run_op(input vec_t v);
    int          k, lat1, lat4, hi1, hi4, held;
    logic        seen1, seen4, done;
    logic [63:0] x;
    lat1 = exp_lat(v.op, v.word, v.a, v.b, 1);
    lat4 = exp_lat(v.op, v.word, v.a, v.b, 4);
    k = 0;
    while (!(in_ready1 && in_ready4) && k < 200) begin @(negedge clk); k++; end
    check("idle_before_issue", {63'b0, in_ready1 & in_ready4}, 64'd1);
    exp_q1.push_back(v.exp);
    exp_q4.push_back(v.exp);
    op = v.op; word = v.word; src1 = v.a; src2 = v.b;
    out_ready = (v.hold == 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen1 = 0; seen4 = 0; hi1 = 0; hi4 = 0; held = 0; done = 0; k = 1;
    while (!done && k <= 150) begin
      if (out_valid1) begin
        hi1++;
        if (!seen1) begin
          seen1 = 1;
          check("latency_mb1", 64'(k), 64'(lat1));
          x = exp_q1.pop_front();
          check("result_mb1", result1, x);
        end else check("held_result_mb1", result1, v.exp);
      end
      if (out_valid4) begin
        hi4++;
        if (!seen4) begin
          seen4 = 1;
          check("latency_mb4", 64'(k), 64'(lat4));
          x = exp_q4.pop_front();
          check("result_mb4", result4, x);
        end else check("held_result_mb4", result4, v.exp);
      end
      if (out_valid1 && held < v.hold) begin
        check("in_ready_while_held", {63'b0, in_ready1}, 64'd0);
        held++;
        in_valid = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        src1 = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
        if (out_valid1) out_ready = 1'b1;
      end
      if (seen1 && seen4 && !out_valid1 && !out_valid4) begin
        done = 1;
        check("in_ready_after_handshake", {62'b0, in_ready1, in_ready4}, 64'd3);
        check("valid_cycles_mb1", 64'(hi1), 64'(v.hold + 1));
        check("valid_cycles_mb4", 64'(hi4), 64'(v.hold + 1));
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL op_timeout: op %0d word %0d got no result within %0d cycles, required %0d",
               v.op, v.word, k, lat1);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
  endtask

  // Starts a DIV, kills it at T+10 by flush or reset, and checks the unit goes idle.
  task automatic abort_case(input logic use_rst);
    int nv;
    nv = 0;
    op = 3'b100; word = 1'b0; src1 = 64'hFFFF_FFFF_FFFF_FFF9; src2 = 64'd2;
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (out_valid1 || out_valid4) nv++;
      if (k == 10) begin
        if (use_rst) rst_n = 1'b0;
        else flush = 1'b1;
      end
      if (k == 11) begin
        rst_n = 1'b1;
        flush = 1'b0;
        check("abort_in_ready", {62'b0, in_ready1, in_ready4}, 64'd3);
        check("abort_busy", {62'b0, busy1, busy4}, 64'd0);
        if (use_rst) begin
          check("reset_result_mb1", result1, 64'd0);
          check("reset_result_mb4", result4, 64'd0);
        end
      end
      @(negedge clk);
    end
    check("abort_no_valid", 64'(nv), 64'd0);
    run_op(mk(3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_result_mb1", result1, 64'd0);
    check("reset_result_mb4", result4, 64'd0);
    check("reset_out_valid", {62'b0, out_valid1, out_valid4}, 64'd0);
    check("reset_busy", {62'b0, busy1, busy4}, 64'd0);
    check("reset_in_ready", {62'b0, in_ready1, in_ready4}, 64'd3);
    rst_n = 1'b1;
    @(negedge clk);

    tbl.push_back(mk(3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0));
    tbl.push_back(mk(3'b011, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0));
    tbl.push_back(mk(3'b001, 0, '1, '1, 64'd0, 0));
    tbl.push_back(mk(3'b010, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(3'b000, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0));
    tbl.push_back(mk(3'b100, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0));
    tbl.push_back(mk(3'b110, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(3'b101, 0, 64'd100, 64'd7, 64'd14, 0));
    tbl.push_back(mk(3'b111, 0, 64'd100, 64'd7, 64'd2, 0));
    tbl.push_back(mk(3'b101, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(3'b110, 0, 64'd5, 64'd0, 64'd5, 0));
    tbl.push_back(mk(3'b100, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0));
    tbl.push_back(mk(3'b100, 1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0));
    tbl.push_back(mk(3'b110, 1, 64'h1234_5678_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(3'b101, 1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(3'b111, 1, 64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0001, 0));
    tbl.push_back(mk(3'b001, 1, 64'd5, 64'd6, 64'd0, 0));
    tbl.push_back(mk(3'b101, 0, 64'd100, 64'd7, 64'd14, 5));
    tbl.push_back(mk(3'b000, 0, 64'd3, 64'd4, 64'd12, 0));

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  o;
      logic        w;
      logic [63:0] a, b;
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 9));
        2: b = '1;
        default: b = {$urandom, $urandom};
      endcase
      tbl.push_back(mk(o, w, a, b, ref_model(o, w, a, b), 0));
    end

    foreach (tbl[i]) run_op(tbl[i]);

    abort_case(1'b0);
    abort_case(1'b1);

    check("scoreboard_empty_mb1", 64'(exp_q1.size()), 64'd0);
    check("scoreboard_empty_mb4", 64'(exp_q4.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV64M multiply/divide execute unit, parametrised in datapath width and multiply step size.
- Sits beside the single-cycle ALU in the execute stage.
- Decode routes M-extension instructions here; the pipeline stalls on in_ready/out_valid.
- Covers word (W-suffix) variants with sign-extended results, and handles RISC-V divide-by-zero and overflow without trapping.

Parameters:
- XLEN, 64, operand/result width; must be even and at least 32.
- MUL_BITS, 1, multiplier bits retired per cycle in multiply; legal values 1, 2, 4; must divide XLEN/2.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  pipeline flush; aborts any operation in flight
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- word  input  1  1 = W variant (operate on [31:0], sign-extend result)
- src1  input  XLEN  rs1 value
- src2  input  XLEN  rs2 value
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  operation result
- busy  output  1  state != IDLE

Behaviour:
- One clock, clk. Reset rst_n is synchronous, active-low.
- Reset values:
  - State IDLE.
  - out_valid 0, result 0, busy 0, in_ready 1.
  - Internal accumulators and counter all 0.
- States:
  - IDLE: in_ready=1. On accept (in_valid&in_ready), latch op/word/operands. Go to DONE if fast path, else CALC.
  - CALC: in_ready=0. Iterate; when counter reaches 0, form the final result and go to DONE.
  - DONE: out_valid=1 and result held stable. On out_ready, go to IDLE.
- in_ready is asserted only in IDLE. A new request can be accepted no earlier than the cycle after the result handshake.
- Operand width: W = word ? 32 : XLEN.
  - Word operands are src[31:0].
  - Signed operands are sign-extended internally; unsigned operands are zero-extended.
- Multiply:
  - Signed operands are converted to magnitudes (MULH: both signed; MULHSU: src1 only; MULHU, MUL: either form is valid for the low half).
  - Shift-add over a 2W product, MUL_BITS multiplier bits per cycle, for W/MUL_BITS CALC cycles.
  - Product is negated if the sign flag is set.
  - MUL returns product[W-1:0]; MULH* return product[2W-1:W].
  - MULW returns the low 32 bits sign-extended.
  - word with op 001-011 is not a legal encoding. It takes the fast path with result 0.
- Divide:
  - Restoring divider on magnitudes, 1 quotient bit per cycle, W CALC cycles.
  - Quotient sign = s1 XOR s2 (signed ops only). Remainder sign = dividend sign.
- Fast path (no CALC, out_valid the cycle after accept):
  - Divisor (W bits) == 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = -2^(W-1), divisor = -1): quotient = dividend; remainder = 0.
  - Illegal word-MULH encodings, as above.
- Word results: always sign-extend bit 31 to XLEN, including DIVUW/REMUW and the fast-path results.
- Latency from accept cycle T to first out_valid cycle:
  - Multiply: T + W/MUL_BITS + 1.
  - Divide: T + W + 1.
  - Fast path: T + 1.
  - Back-pressure extends DONE indefinitely; result must not change while out_valid=1 and out_ready=0.
- Counter width: clog2(XLEN)+1. It is loaded at accept and decremented each CALC cycle.
- Flush:
  - flush=1 in any state forces IDLE next cycle with out_valid=0; the pending result is discarded.
  - flush has priority over accept and over the out_ready handshake in the same cycle.
- Reset mid-operation behaves as flush, and additionally clears result.
- in_valid while busy is ignored; no state change.

Test Plan:
1. Accept MUL src1=7, src2=0xFFFF_FFFF_FFFF_FFFD, out_ready=1, MUL_BITS=1 -> out_valid at T+65 for exactly one cycle; result=0xFFFF_FFFF_FFFF_FFEB. Repeat with MUL_BITS=4 -> out_valid at T+17, same result.
2. MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands -> result=0. MULW src1=0x7FFF_FFFF, src2=2 -> result=0xFFFF_FFFF_FFFF_FFFE at T+33.
3. DIV src1=-7, src2=2 -> result=0xFFFF_FFFF_FFFF_FFFD at T+65. REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Fast path:
   - DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1.
   - REM 5/0 -> 5 at T+1.
   - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 at T+1.
   - DIVW src1=0x0000_0001_8000_0000, src2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at T+1.
5. Back-pressure: DIVU 100/7 with out_ready=0 for 5 cycles after out_valid -> result stays 14 and in_ready stays 0. in_valid pulses during this time are ignored. out_ready=1 -> in_ready=1 next cycle; a back-to-back accept then works.
6. Flush and reset:
   - Start DIV, flush=1 at T+10 -> out_valid never asserts; in_ready=1 at T+11. A following MUL 3*4 returns 12.
   - Repeat with rst_n=0 at T+10 -> same, and result reads 0.
